// File: rtl/alu_stream_if.sv
// Operand/result exchange between the pattern source, the ALU stream block
// and the downstream checker.
interface alu_stream_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] src1;
  logic [31:0] src2;
  logic [3:0]  ALU_control;
  logic [2:0]  bonus_control;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero;
  logic        cout;
  logic        overflow;
  logic        err;

  // Upstream source plus downstream checker side.
  modport master (
    output in_valid, src1, src2, ALU_control, bonus_control, out_ready,
    input  in_ready, out_valid, result, zero, cout, overflow, err
  );

  // ALU stream block side.
  modport slave (
    input  in_valid, src1, src2, ALU_control, bonus_control, out_ready,
    output in_ready, out_valid, result, zero, cout, overflow, err
  );
endinterface

// File: rtl/alu_stream.sv
// Flow-controlled ALU: computes each accepted operation combinationally and
// queues {result, zero, cout, overflow, err} in an in-order buffer whose head
// drives the outputs directly from storage.
module alu_stream #(
  parameter int DEPTH = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  alu_stream_if.slave bus
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  typedef struct packed {
    logic [31:0] result;
    logic        zero;
    logic        cout;
    logic        overflow;
    logic        err;
  } entry_t;

  entry_t        mem_q [DEPTH];
  entry_t        mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW:0]   count_q, count_d;

  entry_t      alu_entry;
  logic [31:0] b_op;
  logic [32:0] sum;
  logic        cin;
  logic        lt, eq, cmp_true, cmp_illegal, illegal;
  logic [31:0] res;
  logic        res_cout, res_ovf;
  logic        push, pop;

  assign bus.in_ready  = rst_n && (count_q != FULL_CNT);
  assign bus.out_valid = (count_q != '0);
  assign push          = bus.in_valid && bus.in_ready;
  assign pop           = bus.out_valid && bus.out_ready;

  assign bus.result    = mem_q[rd_ptr_q].result;
  assign bus.zero      = mem_q[rd_ptr_q].zero;
  assign bus.cout      = mem_q[rd_ptr_q].cout;
  assign bus.overflow  = mem_q[rd_ptr_q].overflow;
  assign bus.err       = mem_q[rd_ptr_q].err;

  // ALU datapath: one shared adder serves ADD and SUB (SUB inverts src2 and
  // injects a carry); set-compare uses a true signed comparison so it is
  // immune to subtraction overflow.
  always_comb begin
    cin         = (bus.ALU_control == 4'd6);
    b_op        = cin ? ~bus.src2 : bus.src2;
    sum         = {1'b0, bus.src1} + {1'b0, b_op} + {32'd0, cin};
    lt          = $signed(bus.src1) < $signed(bus.src2);
    eq          = (bus.src1 == bus.src2);
    cmp_true    = 1'b0;
    cmp_illegal = 1'b0;
    res         = '0;
    res_cout    = 1'b0;
    res_ovf     = 1'b0;
    illegal     = 1'b0;

    case (bus.bonus_control)
      3'd0:    cmp_true = lt;
      3'd1:    cmp_true = !lt && !eq;
      3'd2:    cmp_true = lt || eq;
      3'd3:    cmp_true = !lt;
      3'd4:    cmp_true = !eq;
      3'd6:    cmp_true = eq;
      default: cmp_illegal = 1'b1;
    endcase

    case (bus.ALU_control)
      4'd0:  res = bus.src1 & bus.src2;
      4'd1:  res = bus.src1 | bus.src2;
      4'd2, 4'd6: begin
        res      = sum[31:0];
        res_cout = sum[32];
        res_ovf  = (bus.src1[31] == b_op[31]) && (sum[31] != bus.src1[31]);
      end
      4'd7: begin
        res     = {31'd0, cmp_true};
        illegal = cmp_illegal;
      end
      4'd12: res = ~(bus.src1 | bus.src2);
      4'd13: res = ~(bus.src1 & bus.src2);
      default: illegal = 1'b1;
    endcase

    if (illegal) begin
      res      = '0;
      res_cout = 1'b0;
      res_ovf  = 1'b0;
    end

    alu_entry.result   = res;
    alu_entry.zero     = (res == '0);
    alu_entry.cout     = res_cout;
    alu_entry.overflow = res_ovf;
    alu_entry.err      = illegal;
  end

  // Buffer bookkeeping: tail write on push, pointer/count advance on push/pop.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
      if (push && (wr_ptr_q == PW'(i))) begin
        mem_d[i] = alu_entry;
      end
    end
    wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + (PW+1)'(1);
      2'b01:   count_d = count_q - (PW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // State registers; reset clears storage so the head reads as all-zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end
endmodule

// File: tb/tb_alu_stream.sv
// Bench for alu_stream: directed vectors with literal expectations, plus a
// queue-based reference model compared against the head on every cycle.
module tb_alu_stream;
  localparam int DEPTH = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  bit   mon_en = 1'b0;

  logic [35:0] exp_q [$];
  logic [31:0] popped [$];

  alu_stream_if bus ();

  alu_stream #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [35:0] pack_e(input logic [31:0] r, input bit z, input bit c,
                                         input bit o, input bit e);
    return {r, z, c, o, e};
  endfunction

  // Reference model: plain wide signed/unsigned arithmetic.
  function automatic logic [35:0] model(input logic [3:0] op, input logic [2:0] bs,
                                        input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, sr;
    logic [31:0] r;
    bit c, o, e, t;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r = '0; c = 0; o = 0; e = 0; t = 0; sr = 0;
    case (op)
      4'd0:  r = a & b;
      4'd1:  r = a | b;
      4'd12: r = ~(a | b);
      4'd13: r = ~(a & b);
      4'd2: begin
        sr = sa + sb;
        r  = sr[31:0];
        c  = ({32'd0, a} + {32'd0, b}) > 64'hFFFF_FFFF;
        o  = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
      end
      4'd6: begin
        sr = sa - sb;
        r  = sr[31:0];
        c  = (a >= b);
        o  = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
      end
      4'd7: begin
        case (bs)
          3'd0: t = sa < sb;
          3'd1: t = sa > sb;
          3'd2: t = sa <= sb;
          3'd3: t = sa >= sb;
          3'd4: t = sa != sb;
          3'd6: t = sa == sb;
          default: e = 1;
        endcase
        r = {31'd0, t};
      end
      default: e = 1;
    endcase
    if (e) begin
      r = '0; c = 0; o = 0;
    end
    return pack_e(r, r == 32'd0, c, o, e);
  endfunction

  // Compare process: checks handshake and head against the model each cycle,
  // then applies the push/pop/reset that the coming edge will perform.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("out_valid", bus.out_valid, exp_q.size() != 0);
      chk("in_ready", bus.in_ready, rst_n && (exp_q.size() < DEPTH));
      if (bus.out_valid && exp_q.size() != 0)
        chk("head", {bus.result, bus.zero, bus.cout, bus.overflow, bus.err}, exp_q[0]);
      if (!rst_n) begin
        exp_q.delete();
      end else begin
        if (bus.out_valid && bus.out_ready && exp_q.size() != 0) begin
          popped.push_back(bus.result);
          void'(exp_q.pop_front());
        end
        if (bus.in_valid && bus.in_ready)
          exp_q.push_back(model(bus.ALU_control, bus.bonus_control, bus.src1, bus.src2));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic [3:0] op, input logic [2:0] bs,
                        input logic [31:0] a, input logic [31:0] b);
    bus.ALU_control   = op;
    bus.bonus_control = bs;
    bus.src1          = a;
    bus.src2          = b;
  endtask

  // Present one operation and hold it until accepted (bounded wait).
  task automatic send(input logic [3:0] op, input logic [2:0] bs,
                      input logic [31:0] a, input logic [31:0] b);
    bit acc = 0;
    set_op(op, bs, a, b);
    bus.in_valid = 1'b1;
    for (int i = 0; i < 20 && !acc; i++) begin
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk);
      #1;
    end
    if (!acc) begin
      checks++;
      failures++;
      $display("FAIL send_timeout: op %0d not accepted within 20 cycles", op);
    end
    bus.in_valid = 1'b0;
  endtask

  // One op into an empty buffer: visible the cycle after accept, then popped.
  task automatic run_one(input string name, input logic [3:0] op, input logic [2:0] bs,
                         input logic [31:0] a, input logic [31:0] b, input logic [35:0] exp);
    send(op, bs, a, b);
    chk({name, "_latency"}, bus.out_valid, 1'b1);
    chk(name, {bus.result, bus.zero, bus.cout, bus.overflow, bus.err}, exp);
    $display("op=%0d bonus=%0d src1=%h src2=%h -> result=%h z=%0b c=%0b v=%0b err=%0b",
             op, bs, a, b, bus.result, bus.zero, bus.cout, bus.overflow, bus.err);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk({name, "_popped"}, bus.out_valid, 1'b0);
  endtask

  task automatic drain();
    for (int i = 0; i < 10 && bus.out_valid; i++) tick();
    chk("drain_done", bus.out_valid, 1'b0);
  endtask

  initial begin
    int c0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    set_op(4'd0, 3'd0, 32'd0, 32'd0);

    // Reset state
    tick();
    tick();
    mon_en = 1'b1;
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_in_ready", bus.in_ready, 1'b0);
    chk("rst_head", {bus.result, bus.zero, bus.cout, bus.overflow, bus.err}, 36'd0);
    rst_n = 1'b1;
    #1;
    chk("release_in_ready", bus.in_ready, 1'b1);

    // Directed vectors with hand-computed results
    run_one("add_ovf",  4'd2, 3'd0, 32'h7FFF_FFFF, 32'h1, pack_e(32'h8000_0000, 0, 0, 1, 0));
    run_one("add_wrap", 4'd2, 3'd0, 32'hFFFF_FFFF, 32'h1, pack_e(32'h0, 1, 1, 0, 0));
    run_one("sub_eq",   4'd6, 3'd0, 32'd5, 32'd5, pack_e(32'h0, 1, 1, 0, 0));
    run_one("sub_ovf",  4'd6, 3'd0, 32'h8000_0000, 32'h1, pack_e(32'h7FFF_FFFF, 0, 1, 1, 0));
    run_one("slt",      4'd7, 3'd0, 32'hFFFF_FFFF, 32'h1, pack_e(32'h1, 0, 0, 0, 0));
    run_one("sgt",      4'd7, 3'd1, 32'hFFFF_FFFF, 32'h1, pack_e(32'h0, 1, 0, 0, 0));
    run_one("sle",      4'd7, 3'd2, 32'hFFFF_FFFF, 32'h1, pack_e(32'h1, 0, 0, 0, 0));
    run_one("sge",      4'd7, 3'd3, 32'hFFFF_FFFF, 32'h1, pack_e(32'h0, 1, 0, 0, 0));
    run_one("sne",      4'd7, 3'd4, 32'hFFFF_FFFF, 32'h1, pack_e(32'h1, 0, 0, 0, 0));
    run_one("seq",      4'd7, 3'd6, 32'hFFFF_FFFF, 32'h1, pack_e(32'h0, 1, 0, 0, 0));
    run_one("sel5",     4'd7, 3'd5, 32'hFFFF_FFFF, 32'h1, pack_e(32'h0, 1, 0, 0, 1));
    run_one("sel7",     4'd7, 3'd7, 32'hFFFF_FFFF, 32'h1, pack_e(32'h0, 1, 0, 0, 1));
    run_one("slt_ext",  4'd7, 3'd0, 32'h8000_0000, 32'h7FFF_FFFF, pack_e(32'h1, 0, 0, 0, 0));
    run_one("sgt_ext",  4'd7, 3'd1, 32'h8000_0000, 32'h7FFF_FFFF, pack_e(32'h0, 1, 0, 0, 0));
    run_one("op3",      4'd3, 3'd0, 32'h1234_5678, 32'h1, pack_e(32'h0, 1, 0, 0, 1));
    run_one("nand",     4'd13, 3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, pack_e(32'h0, 1, 0, 0, 0));

    // Throughput: one op per cycle with out_ready held high
    bus.out_ready = 1'b1;
    c0 = cyc;
    send(4'd2, 3'd0, 32'd10, 32'd20);
    send(4'd6, 3'd0, 32'd3, 32'd7);
    send(4'd0, 3'd0, 32'hAAAA_5555, 32'hFF00_FF00);
    send(4'd1, 3'd0, 32'h0000_1234, 32'h5678_0000);
    send(4'd12, 3'd0, 32'h0, 32'h0);
    send(4'd7, 3'd3, 32'h7FFF_FFFF, 32'h8000_0000);
    chk("throughput_cycles", cyc - c0, 6);
    $display("throughput: 6 ops in %0d cycles", cyc - c0);
    drain();
    bus.out_ready = 1'b0;

    // Backpressure: fill, hold NOR, then drain in order
    popped.delete();
    send(4'd0, 3'd0, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
    chk("bp_ready_after_1", bus.in_ready, 1'b1);
    send(4'd1, 3'd0, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
    chk("bp_ready_after_2", bus.in_ready, 1'b0);
    set_op(4'd12, 3'd0, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
    bus.in_valid = 1'b1;
    tick();
    tick();
    chk("bp_held", bus.in_ready, 1'b0);
    bus.out_ready = 1'b1;
    send(4'd12, 3'd0, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
    drain();
    bus.out_ready = 1'b0;
    chk("bp_count", popped.size(), 3);
    if (popped.size() == 3) begin
      chk("bp_and", popped[0], 32'h00F0_00F0);
      chk("bp_or",  popped[1], 32'hFFF0_FFF0);
      chk("bp_nor", popped[2], 32'h000F_000F);
    end
    $display("backpressure: drained %0d results", popped.size());

    // Reset with a full buffer and a pending op
    send(4'd2, 3'd0, 32'd3, 32'd4);
    send(4'd2, 3'd0, 32'd5, 32'd6);
    chk("full_in_ready", bus.in_ready, 1'b0);
    set_op(4'd2, 3'd0, 32'd9, 32'd9);
    bus.in_valid = 1'b1;
    rst_n = 1'b0;
    tick();
    chk("rst_full_out_valid", bus.out_valid, 1'b0);
    chk("rst_full_in_ready", bus.in_ready, 1'b0);
    bus.in_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
    chk("rst_full_release", bus.in_ready, 1'b1);
    popped.delete();
    bus.out_ready = 1'b1;
    send(4'd2, 3'd0, 32'd1, 32'd1);
    tick();
    tick();
    bus.out_ready = 1'b0;
    chk("post_rst_count", popped.size(), 1);
    if (popped.size() != 0) chk("post_rst_first", popped[0], 32'd2);
    $display("post-reset: first result %0h", (popped.size() != 0) ? popped[0] : 32'hDEAD);

    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
